shift_arbiter_ctrl: RTL and testbench

Controller that shares one serial left-shift datapath between two requesters. It arbitrates between the requesters using round-robin and captures the granted operand and shift amount. It then shifts one bit per clock, without using a shift operator, and presents the result on a valid/ready output with the requester ID. It sits in front of the Day-series shift datapath and sequences every operation on it.

---
 rtl/shift_arbiter_ctrl_pkg.sv | 14 +
 rtl/shift_arbiter_ctrl_shift_step.sv | 16 +
 rtl/shift_arbiter_ctrl.sv | 134 +++++++++++++
 tb/tb_shift_arbiter_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_arbiter_ctrl_pkg.sv
// Shared types and constants for the round-robin shift arbiter controller.
// Requester IDs are 1-bit encodings that appear directly on res_id.
package shift_arbiter_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic ID_REQ0 = 1'b0;
   localparam logic ID_REQ1 = 1'b1;

endpackage

// File: rtl/shift_arbiter_ctrl_shift_step.sv
// One-bit left shift built from a concatenation, with no shift operator.
// The bit shifted into the LSB is zero, or the old MSB when ROTATE is set.
module shift_step #(
   parameter int DATA_W = 8,
   parameter int ROTATE = 0
) (
   input  logic [DATA_W-1:0] i_data,
   output logic [DATA_W-1:0] o_data
);

   logic w_fill;

   assign w_fill = (ROTATE != 0) ? i_data[DATA_W-1] : 1'b0;
   assign o_data = {i_data[DATA_W-2:0], w_fill};

endmodule

// File: rtl/shift_arbiter_ctrl.sv
// Round-robin arbiter for two requesters sharing one serial left-shift datapath.
// The result appears on a valid/ready port together with the owning requester ID.
module shift_arbiter_ctrl
   import shift_arbiter_ctrl_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int AMT_W  = 3,
   parameter int ROTATE = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_data,
   input  logic [AMT_W-1:0]  req0_amt,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_data,
   input  logic [AMT_W-1:0]  req1_amt,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [DATA_W-1:0] res_data,
   output logic              res_id,
   output logic              busy,
   output state_t            dbg_state
);

   // Handshakes: a transfer happens on any rising edge where valid and ready
   // are both high. Requesters hold data/amt stable while valid is high and
   // ready is low; the result port holds res_data/res_id until res_ready.

   state_t            r_state;
   logic [DATA_W-1:0] r_sh;
   logic [AMT_W-1:0]  r_cnt;
   logic [DATA_W-1:0] r_res_data;
   logic              r_res_id;
   logic              r_res_valid;
   logic              r_busy;
   logic              r_last_id;

   logic              w_grant;
   logic              w_idle;
   logic              w_accept;
   logic [DATA_W-1:0] w_cap_data;
   logic [AMT_W-1:0]  w_cap_amt;
   logic [DATA_W-1:0] w_sh_next;

   always_comb begin
      w_grant = ID_REQ0;
      if (req0_valid && req1_valid) begin
         w_grant = ~r_last_id;
      end else if (req1_valid) begin
         w_grant = ID_REQ1;
      end
   end

   assign w_idle     = (r_state == IDLE);
   assign w_accept   = w_idle && (req0_valid || req1_valid);
   assign w_cap_data = (w_grant == ID_REQ1) ? req1_data : req0_data;
   assign w_cap_amt  = (w_grant == ID_REQ1) ? req1_amt  : req0_amt;

   // Ready is gated by reset so nothing looks accepted while reset is held.
   assign req0_ready = ~reset && w_idle && req0_valid && (w_grant == ID_REQ0);
   assign req1_ready = ~reset && w_idle && req1_valid && (w_grant == ID_REQ1);

   shift_step #(
      .DATA_W (DATA_W),
      .ROTATE (ROTATE)
   ) u_shift_step (
      .i_data (r_sh),
      .o_data (w_sh_next)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_sh        <= '0;
         r_cnt       <= '0;
         r_res_data  <= '0;
         r_res_id    <= ID_REQ0;
         r_res_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_last_id   <= ID_REQ1;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_sh      <= w_cap_data;
                  r_cnt     <= w_cap_amt;
                  r_res_id  <= w_grant;
                  r_last_id <= w_grant;
                  r_busy    <= 1'b1;
                  if (w_cap_amt == '0) begin
                     r_res_data  <= w_cap_data;
                     r_res_valid <= 1'b1;
                     r_state     <= DONE;
                  end else begin
                     r_state <= SHIFT;
                  end
               end
            end
            SHIFT: begin
               r_sh  <= w_sh_next;
               r_cnt <= r_cnt - 1'b1;
               // Counter at one means this edge performs the final shift.
               if (r_cnt == AMT_W'(1)) begin
                  r_res_data  <= w_sh_next;
                  r_res_valid <= 1'b1;
                  r_state     <= DONE;
               end
            end
            DONE: begin
               if (res_ready) begin
                  r_res_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_res_valid <= 1'b0;
               r_busy      <= 1'b0;
               r_state     <= IDLE;
            end
         endcase
      end
   end

   assign res_valid = r_res_valid;
   assign res_data  = r_res_data;
   assign res_id    = r_res_id;
   assign busy      = r_busy;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_shift_arbiter_ctrl.sv
// Bench for shift_arbiter_ctrl: a zero-fill and a rotate instance share stimulus,
// each with its own expected-result queue, plus directed latency/priority checks.
module tb_shift_arbiter_ctrl;
   import shift_arbiter_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       req0_valid, req1_valid, res_ready;
   logic [7:0] req0_data, req1_data;
   logic [2:0] req0_amt, req1_amt;

   logic       req0_ready, req1_ready, res_valid, res_id, busy;
   logic [7:0] res_data;
   state_t     dbg_state;

   logic       rot_req0_ready, rot_req1_ready, rot_res_valid, rot_res_id, rot_busy;
   logic [7:0] rot_res_data;
   state_t     rot_dbg_state;

   logic [8:0] exp_q0[$];
   logic [8:0] exp_q1[$];
   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   shift_arbiter_ctrl #(.DATA_W(8), .AMT_W(3), .ROTATE(0)) u_dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_amt(req0_amt),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_amt(req1_amt),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id),
      .busy(busy), .dbg_state(dbg_state)
   );

   shift_arbiter_ctrl #(.DATA_W(8), .AMT_W(3), .ROTATE(1)) u_dut_rot (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(rot_req0_ready), .req0_data(req0_data), .req0_amt(req0_amt),
      .req1_valid(req1_valid), .req1_ready(rot_req1_ready), .req1_data(req1_data), .req1_amt(req1_amt),
      .res_valid(rot_res_valid), .res_ready(res_ready), .res_data(rot_res_data), .res_id(rot_res_id),
      .busy(rot_busy), .dbg_state(rot_dbg_state)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [8:0] model(input logic id, input logic [7:0] d,
                                        input logic [2:0] a, input bit rot);
      logic [7:0] r;
      r = d << a;
      if (rot && a != 3'd0) r = r | (d >> (8 - int'(a)));
      return {id, r};
   endfunction

   // Scoreboard: push on accepted requests, pop on result handshakes.
   always @(negedge clk) begin
      if (reset) begin
         exp_q0.delete();
         exp_q1.delete();
      end else begin
         if (req0_valid && req0_ready) exp_q0.push_back(model(1'b0, req0_data, req0_amt, 1'b0));
         if (req1_valid && req1_ready) exp_q0.push_back(model(1'b1, req1_data, req1_amt, 1'b0));
         if (req0_valid && rot_req0_ready) exp_q1.push_back(model(1'b0, req0_data, req0_amt, 1'b1));
         if (req1_valid && rot_req1_ready) exp_q1.push_back(model(1'b1, req1_data, req1_amt, 1'b1));
         if (res_valid && res_ready) begin
            check("sb_pending", 32'(exp_q0.size() > 0), 32'd1);
            if (exp_q0.size() > 0) begin
               logic [8:0] e;
               e = exp_q0.pop_front();
               check("sb_data", 32'(res_data), 32'(e[7:0]));
               check("sb_id", 32'(res_id), 32'(e[8]));
            end
         end
         if (rot_res_valid && res_ready) begin
            check("sb_rot_pending", 32'(exp_q1.size() > 0), 32'd1);
            if (exp_q1.size() > 0) begin
               logic [8:0] e;
               e = exp_q1.pop_front();
               check("sb_rot_data", 32'(rot_res_data), 32'(e[7:0]));
               check("sb_rot_id", 32'(rot_res_id), 32'(e[8]));
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a request, wait for its grant, return just after the accept edge.
   task automatic send(input int id, input logic [7:0] d, input logic [2:0] a);
      int n;
      if (id == 0) begin
         req0_valid = 1'b1; req0_data = d; req0_amt = a;
      end else begin
         req1_valid = 1'b1; req1_data = d; req1_amt = a;
      end
      #1;
      n = 0;
      while (!((id == 0) ? req0_ready : req1_ready) && n < 100) begin
         tick();
         n++;
      end
      check("grant_timeout", 32'(n < 100), 32'd1);
      tick();
      if (id == 0) req0_valid = 1'b0;
      else         req1_valid = 1'b0;
   endtask

   task automatic wait_valid(output int k);
      k = 0;
      while (!res_valid && k < 50) begin
         tick();
         k++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int n;
      logic gid;

      // Reset state with req0 already asking.
      reset = 1'b1; res_ready = 1'b1;
      req0_valid = 1'b1; req0_data = 8'b1011_0011; req0_amt = 3'd3;
      req1_valid = 1'b0; req1_data = 8'h00; req1_amt = 3'd0;
      repeat (2) tick();
      check("rst_req0_ready", 32'(req0_ready), 32'd0);
      check("rst_res_valid", 32'(res_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_res_data", 32'(res_data), 32'd0);
      check("rst_state", 32'(dbg_state), 32'(IDLE));
      reset = 1'b0;
      #1;
      check("rel_req0_ready", 32'(req0_ready), 32'd1);

      // req0, amt 3.
      send(0, 8'b1011_0011, 3'd3);
      check("t2_busy", 32'(busy), 32'd1);
      check("t2_state", 32'(dbg_state), 32'(SHIFT));
      wait_valid(k);
      check("t2_latency", 32'(k), 32'd3);
      check("t2_data", 32'(res_data), 32'h98);
      check("t2_id", 32'(res_id), 32'd0);
      tick();
      check("t2_valid_one_cycle", 32'(res_valid), 32'd0);

      // req1, amt 0.
      send(1, 8'hA5, 3'd0);
      wait_valid(k);
      check("t3_latency", 32'(k), 32'd0);
      check("t3_busy", 32'(busy), 32'd1);
      check("t3_data", 32'(res_data), 32'hA5);
      check("t3_id", 32'(res_id), 32'd1);
      tick();
      check("t3_busy_drop", 32'(busy), 32'd0);
      check("t3_valid_drop", 32'(res_valid), 32'd0);

      // Both held: alternating grants.
      req0_valid = 1'b1; req0_data = 8'h81; req0_amt = 3'd1;
      req1_valid = 1'b1; req1_data = 8'h01; req1_amt = 3'd7;
      for (int g = 0; g < 4; g++) begin
         #1;
         n = 0;
         while (!(req0_ready || req1_ready) && n < 50) begin
            tick();
            n++;
         end
         check("t4_grant_timeout", 32'(n < 50), 32'd1);
         gid = req1_ready;
         check("t4_grant_order", 32'(gid), 32'(g % 2));
         tick();
         if (g == 3) begin
            req0_valid = 1'b0; req1_valid = 1'b0;
         end
         wait_valid(k);
         check("t4_data", 32'(res_data), (g % 2 == 0) ? 32'h02 : 32'h80);
         check("t4_rot_data", 32'(rot_res_data), (g % 2 == 0) ? 32'h03 : 32'h80);
         tick();
      end

      // Backpressure on the result port.
      res_ready = 1'b0;
      req1_valid = 1'b1; req1_data = 8'h3C; req1_amt = 3'd1;
      send(0, 8'h0F, 3'd2);
      wait_valid(k);
      check("t5_latency", 32'(k), 32'd2);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t5_valid_hold", 32'(res_valid), 32'd1);
         check("t5_data_hold", 32'(res_data), 32'h3C);
         check("t5_id_hold", 32'(res_id), 32'd0);
         check("t5_ready_low", 32'({req0_ready, req1_ready}), 32'd0);
      end
      res_ready = 1'b1;
      tick();
      check("t5_idle", 32'(dbg_state), 32'(IDLE));
      check("t5_valid_drop", 32'(res_valid), 32'd0);
      check("t5_req1_ready", 32'(req1_ready), 32'd1);
      tick();
      req1_valid = 1'b0;
      wait_valid(k);
      check("t5_req1_data", 32'(res_data), 32'h78);
      check("t5_req1_id", 32'(res_id), 32'd1);
      tick();

      // Reset in the middle of a shift.
      send(0, 8'hFF, 3'd7);
      repeat (3) tick();
      check("t6_busy_pre", 32'(busy), 32'd1);
      reset = 1'b1;
      #1;
      check("t6_valid_async", 32'(res_valid), 32'd0);
      check("t6_busy_async", 32'(busy), 32'd0);
      check("t6_state_async", 32'(dbg_state), 32'(IDLE));
      tick();
      reset = 1'b0;
      #1;
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      check("t6_ptr_req0", 32'(req0_ready), 32'd1);
      check("t6_ptr_req1", 32'(req1_ready), 32'd0);
      req0_valid = 1'b0;
      send(1, 8'h0F, 3'd4);
      wait_valid(k);
      check("t6_latency", 32'(k), 32'd4);
      check("t6_data", 32'(res_data), 32'hF0);
      check("t6_id", 32'(res_id), 32'd1);
      tick();

      n = 0;
      while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 50) begin
         tick();
         n++;
      end
      check("q0_drained", 32'(exp_q0.size()), 32'd0);
      check("q1_drained", 32'(exp_q1.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
